// File: rtl/uart_cmd_bridge_pkg.sv
// uart_cmd_bridge_pkg: command codes, frame tags and bridge FSM states
package uart_cmd_bridge_pkg;
  typedef enum logic [2:0] {
    PIX_WRITE  = 3'd0,
    PIX_READ   = 3'd1,
    SREG_CLEAR = 3'd2,
    WRITE_CFG  = 3'd3,
    WRITE_ADDR = 3'd4,
    WRITE_MASK = 3'd5,
    WRITE_CTRL = 3'd6,
    SREG_READ  = 3'd7
  } cmd_e;
  localparam logic [3:0] HDR_SYNC = 4'hA;
  localparam logic [3:0] ACK_TAG  = 4'h5;
  typedef enum logic [2:0] {
    S_IDLE, S_PAYLOAD, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_ACK, S_RESP
  } state_e;
endpackage

// File: rtl/uart_cmd_bridge_gap_timer.sv
// uart_cmd_bridge_gap_timer: counts idle cycles since clear, saturating at GAP_CYC
module uart_cmd_bridge_gap_timer #(
  parameter int GAP_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expire
);
  localparam int CW = $clog2(GAP_CYC + 1);
  logic [CW-1:0] cnt;
  assign expire = cnt == CW'(GAP_CYC);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clear ? '0 : expire ? cnt : cnt + 1'b1;
endmodule

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: turns UART byte frames into sreg_ctrl commands and streams ack/response bytes back
module uart_cmd_bridge
  import uart_cmd_bridge_pkg::*;
#(
  parameter int                    DATA_W      = 42,
  parameter int                    CMD_W       = 3,
  parameter logic [(1<<CMD_W)-1:0] PAYLOAD_MSK = 'b01111001,
  parameter logic [(1<<CMD_W)-1:0] RESP_MSK    = 'b10000010,
  parameter int                    GAP_CYC     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              cmd_valid,
  output logic [CMD_W-1:0]  cmd,
  output logic [DATA_W-1:0] data_in,
  input  logic              cmd_ready,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              err_sync,
  output logic              err_timeout,
  output logic              err_overrun
);
  localparam int NB = (DATA_W + 7) / 8;
  localparam int KW = $clog2(NB + 1);
  state_e state, state_nx;
  logic [KW-1:0] k;
  logic [DATA_W-1:0] resp_q;
  logic expire, hdr_ok, last;
  assign hdr_ok    = rx_valid && rx_data[7:4] == HDR_SYNC;
  assign last      = k == KW'(NB - 1);
  assign busy      = state != S_IDLE;
  assign cmd_valid = state == S_ISSUE;
  assign tx_valid  = state == S_ACK || state == S_RESP;
  assign tx_data   = state == S_ACK ? {ACK_TAG, 4'(cmd)} : resp_q[7:0];
  uart_cmd_bridge_gap_timer #(.GAP_CYC(GAP_CYC)) u_gap (
    .clk(clk), .rst_n(rst_n), .clear(state != S_PAYLOAD || rx_valid), .expire(expire)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (hdr_ok) state_nx = PAYLOAD_MSK[rx_data[CMD_W-1:0]] ? S_PAYLOAD : S_ISSUE;
      S_PAYLOAD:   state_nx = expire ? S_IDLE : (rx_valid && last) ? S_ISSUE : S_PAYLOAD;
      S_ISSUE:     if (cmd_ready) state_nx = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!cmd_ready) state_nx = S_WAIT_DONE;
      S_WAIT_DONE: if (cmd_ready) state_nx = S_ACK;
      S_ACK:       if (tx_ready) state_nx = RESP_MSK[cmd] ? S_RESP : S_IDLE;
      S_RESP:      if (tx_ready && last) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end
  // Timeout outranks a byte arriving in the same cycle, so the byte is simply not stored
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd         <= '0;
      data_in     <= '0;
      resp_q      <= '0;
      k           <= '0;
      err_sync    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_sync    <= state == S_IDLE && rx_valid && !hdr_ok;
      err_timeout <= state == S_PAYLOAD && expire;
      err_overrun <= rx_valid && !(state inside {S_IDLE, S_PAYLOAD});
      case (state)
        S_IDLE: if (hdr_ok) begin
          cmd     <= rx_data[CMD_W-1:0];
          data_in <= '0;
          k       <= '0;
        end
        S_PAYLOAD:
          if (expire) k <= '0;
          else if (rx_valid) begin
            for (int i = 0; i < DATA_W; i++)
              if (k == KW'(i / 8)) data_in[i] <= rx_data[i % 8];
            k <= last ? '0 : k + 1'b1;
          end
        S_WAIT_DONE: if (cmd_ready) begin
          resp_q <= data_out;
          k      <= '0;
        end
        S_RESP: if (tx_ready) begin
          resp_q <= resp_q >> 8;
          k      <= last ? '0 : k + 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb_uart_cmd_bridge: randomized frames checked against a byte-level model of the bridge protocol
module tb_uart_cmd_bridge;
  localparam int GAP = 1024;
  localparam logic [7:0] PMSK = 8'b01111001;
  localparam logic [7:0] RMSK = 8'b10000010;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rx_data = '0, tx_data;
  logic rx_valid = 1'b0, tx_valid, tx_ready = 1'b0;
  logic cmd_valid, cmd_ready = 1'b1, busy, err_sync, err_timeout, err_overrun;
  logic [2:0] cmd;
  logic [41:0] data_in, data_out = '0;
  int checks = 0, failures = 0;
  int n_acc = 0, n_sync = 0, n_to = 0, n_ovr = 0, n_multi = 0;

  uart_cmd_bridge #(.DATA_W(42), .CMD_W(3), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cmd_valid(cmd_valid), .cmd(cmd), .data_in(data_in), .cmd_ready(cmd_ready),
    .data_out(data_out), .busy(busy), .err_sync(err_sync),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) n_acc++;
    if (err_sync) n_sync++;
    if (err_timeout) n_to++;
    if (err_overrun) n_ovr++;
    if (int'(err_sync) + int'(err_timeout) + int'(err_overrun) > 1) n_multi++;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // One full transaction: frame in, handshake, ack and response bytes out
  task automatic exec_cmd(input logic [2:0] c, input logic [47:0] pl, input logic [41:0] rv, input bit ovr);
    logic [41:0] edin;
    logic [7:0] exp_q[$], got_q[$];
    int n, acc0, ovr0;
    edin = PMSK[c] ? pl[41:0] : '0;
    acc0 = n_acc; ovr0 = n_ovr;
    exp_q.push_back({4'h5, 1'b0, c});
    if (RMSK[c]) for (int j = 0; j < 6; j++) exp_q.push_back(8'({6'b0, rv} >> (8 * j)));
    if (PMSK[c]) begin
      send_byte({4'hA, 1'b0, c}, $urandom_range(0, 3));
      for (int j = 0; j < 6; j++) send_byte(pl[8*j +: 8], j == 5 ? 0 : $urandom_range(0, 3));
    end else send_byte({4'hA, 1'b0, c}, 0);
    checks++;
    if (cmd_valid !== 1'b1) begin failures++; $display("FAIL issue_latency cmd=%0d cmd_valid=%b want 1", c, cmd_valid); end
    n = 0;
    while (cmd_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (cmd !== c) begin failures++; $display("FAIL cmd got=%0d want=%0d", cmd, c); end
    checks++;
    if (data_in !== edin) begin failures++; $display("FAIL data_in cmd=%0d got=%h want=%h", c, data_in, edin); end
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0) begin failures++; $display("FAIL cmd_valid_drop got=%b want 0", cmd_valid); end
    cmd_ready = 1'b0;
    @(negedge clk);
    if (ovr) begin rx_data = 8'($urandom); rx_valid = 1'b1; @(negedge clk); rx_valid = 1'b0; end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    data_out = rv; cmd_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
      failures++; $display("FAIL ack_latency cmd=%0d tx_valid=%b tx_data=%h want 1/%h", c, tx_valid, tx_data, exp_q[0]);
    end
    n = 0;
    while (busy && n < 200) begin
      tx_ready = 1'($urandom_range(0, 1));
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      @(negedge clk); n++;
    end
    tx_ready = 1'b0;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL tx_count cmd=%0d got=%0d want=%0d", c, got_q.size(), exp_q.size());
    end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      checks++;
      if (got_q[j] !== exp_q[j]) begin failures++; $display("FAIL tx_byte%0d cmd=%0d got=%h want=%h", j, c, got_q[j], exp_q[j]); end
    end
    checks++;
    if (n_acc != acc0 + 1) begin failures++; $display("FAIL handshakes cmd=%0d got=%0d want=1", c, n_acc - acc0); end
    checks++;
    if (n_ovr - ovr0 != int'(ovr)) begin failures++; $display("FAIL overrun_count got=%0d want=%0d", n_ovr - ovr0, int'(ovr)); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_valid, cmd_valid, busy, err_sync, err_timeout, err_overrun} !== 6'b0 || data_in !== '0 || cmd !== '0 || tx_data !== '0) begin
      failures++; $display("FAIL reset_outputs flags=%b data_in=%h cmd=%0d tx_data=%h want all 0",
        {tx_valid, cmd_valid, busy, err_sync, err_timeout, err_overrun}, data_in, cmd, tx_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write;
    exec_cmd(3'd0, 48'h02_4B_B5_F6_C9_2B, 42'($urandom), 1'b0);
  endtask

  task automatic test_read;
    exec_cmd(3'd7, 48'h0, 42'h3_0000_0001, 1'b0);
  endtask

  task automatic test_sync;
    int s0, a0;
    s0 = n_sync; a0 = n_acc;
    send_byte(8'h37, 4);
    checks++;
    if (n_sync != s0 + 1 || busy !== 1'b0 || n_acc != a0) begin
      failures++; $display("FAIL sync_err pulses=%0d busy=%b handshakes=%0d want 1/0/0", n_sync - s0, busy, n_acc - a0);
    end
    exec_cmd(3'd1, 48'h0, {$urandom, 10'($urandom)}, 1'b0);
  endtask

  task automatic test_timeout;
    int t0, a0, n;
    t0 = n_to; a0 = n_acc;
    send_byte(8'hA3, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    n = 0;
    while (n_to == t0 && n < GAP + 50) begin @(negedge clk); n++; end
    checks++;
    if (n_to != t0 + 1) begin failures++; $display("FAIL timeout_pulse got=%0d want=1", n_to - t0); end
    checks++;
    if (busy !== 1'b0 || n_acc != a0) begin failures++; $display("FAIL timeout_idle busy=%b handshakes=%0d want 0/0", busy, n_acc - a0); end
    exec_cmd(3'd4, {$urandom, 16'($urandom)}, 42'($urandom), 1'b0);
  endtask

  task automatic test_overrun;
    exec_cmd(3'd7, 48'h0, {$urandom, 10'($urandom)}, 1'b1);
    exec_cmd(3'd5, {$urandom, 16'($urandom)}, 42'($urandom), 1'b1);
  endtask

  task automatic test_reset_mid_resp;
    send_byte(8'hA7, 0);
    @(negedge clk);
    cmd_ready = 1'b0;
    @(negedge clk);
    data_out = 42'h2AA_5555_AAAA; cmd_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1) begin failures++; $display("FAIL resp_pending tx_valid=%b want 1", tx_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset tx_valid=%b busy=%b cmd_valid=%b want 0", tx_valid, busy, cmd_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exec_cmd(3'd2, 48'h0, 42'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 20; i++) begin
      logic [2:0] c;
      c = 3'($urandom);
      exec_cmd(c, {$urandom, 16'($urandom)}, {$urandom, 10'($urandom)}, 1'($urandom_range(0, 3) == 0));
    end
    checks++;
    if (n_multi != 0) begin failures++; $display("FAIL err_exclusive overlaps=%0d want 0", n_multi); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_sync();
    test_timeout();
    test_overrun();
    test_reset_mid_resp();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
